// File: rtl/matmul_stream_nxn_pkg.sv
// Shared definitions for the streaming NxN multiplier: FSM encoding, legal
// matrix sizes and accumulator sizing.
package matmul_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD_A  = 3'd1;
  localparam logic [2:0] ST_LOAD_B  = 3'd2;
  localparam logic [2:0] ST_COMPUTE = 3'd3;
  localparam logic [2:0] ST_OUT     = 3'd4;

  localparam int PN_MIN = 2;
  localparam int PN_MAX = 8;

  // Room for pN full-width products without overflow.
  function automatic int acc_width(input int data_w, input int n);
    return 2 * data_w + $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_stream_nxn_if.sv
// AXI-Stream beat bundle used for both the operand (slave) and result (master) streams.
interface matmul_stream_nxn_if #(
  parameter int pDATA_WIDTH = 32
) ();
  logic                   tvalid;
  logic                   tready;
  logic [pDATA_WIDTH-1:0] tdata;
  logic                   tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/matmul_stream_nxn_dot.sv
// Combinational pN-way dot product of one A row and one B column, 0 cycles,
// no flow control; signed/unsigned operands, result wraps to pDATA_WIDTH bits.
module matmul_dot_n
  import matmul_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pN          = 4
) (
  input  logic                      is_signed,
  input  logic [pN*pDATA_WIDTH-1:0] a_row,
  input  logic [pN*pDATA_WIDTH-1:0] b_col,
  output logic [pDATA_WIDTH-1:0]    dot
);
  localparam int PW = 2 * pDATA_WIDTH;
  localparam int AW = acc_width(pDATA_WIDTH, pN);

  logic [AW-1:0] term [pN];
  logic [AW-1:0] acc;
  logic          acc_unused;

  for (genvar k = 0; k < pN; k++) begin : g_term
    logic [pDATA_WIDTH-1:0] a_k, b_k;
    logic [PW-1:0]          a_x, b_x, prod;
    assign a_k = a_row[k*pDATA_WIDTH +: pDATA_WIDTH];
    assign b_k = b_col[k*pDATA_WIDTH +: pDATA_WIDTH];
    assign a_x = is_signed ? {{pDATA_WIDTH{a_k[pDATA_WIDTH-1]}}, a_k} : {{pDATA_WIDTH{1'b0}}, a_k};
    assign b_x = is_signed ? {{pDATA_WIDTH{b_k[pDATA_WIDTH-1]}}, b_k} : {{pDATA_WIDTH{1'b0}}, b_k};
    // Low PW bits of the extended product equal the true product in either mode.
    assign prod    = a_x * b_x;
    assign term[k] = is_signed ? {{(AW-PW){prod[PW-1]}}, prod} : {{(AW-PW){1'b0}}, prod};
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < pN; k++) begin
      acc = acc + term[k];
    end
    dot        = acc[pDATA_WIDTH-1:0];
    acc_unused = ^acc[AW-1:pDATA_WIDTH];
  end

endmodule

// File: rtl/matmul_stream_nxn.sv
// Streaming C = A x B (pN x pN, row-major in and out); first result N*N+1 cycles after last B beat.
// Input stalls (ss.tready=0) during COMPUTE/OUT; result beat holds while sm.tready is low.
module matmul_stream_nxn
  import matmul_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pN          = 4,
  parameter int pIDX_W      = $clog2(pN * pN)
) (
  input  logic                axis_clk,
  input  logic                axis_rst_n,
  matmul_stream_nxn_if.slave  ss,
  matmul_stream_nxn_if.master sm,
  input  logic                cfg_signed,
  output logic                busy,
  output logic                err
);
  localparam int                NN       = pN * pN;
  localparam logic [pIDX_W-1:0] IDX_LAST = pIDX_W'(NN - 1);
  localparam logic [pIDX_W-1:0] N_IDX    = pIDX_W'(pN);

  logic [2:0]                state;
  logic [pIDX_W-1:0]         idx, row, col;
  logic                      signed_q;
  logic [pDATA_WIDTH-1:0]    a_buf [NN];
  logic [pDATA_WIDTH-1:0]    b_buf [NN];
  logic [pDATA_WIDTH-1:0]    c_buf [NN];
  logic [pN*pDATA_WIDTH-1:0] a_row, b_col;
  logic [pDATA_WIDTH-1:0]    dot;
  logic                      ss_hs, at_last;

  // Reset is active-high despite its name; hold off the upstream while it is asserted.
  assign ss.tready = !axis_rst_n &&
                     (state == ST_IDLE || state == ST_LOAD_A || state == ST_LOAD_B);
  assign ss_hs     = ss.tvalid && ss.tready;
  assign at_last   = (idx == IDX_LAST);
  assign busy      = (state != ST_IDLE);
  assign sm.tvalid = (state == ST_OUT);
  assign sm.tlast  = sm.tvalid && at_last;
  assign sm.tdata  = sm.tvalid ? c_buf[idx] : '0;

  assign row = idx / N_IDX;
  assign col = idx % N_IDX;

  always_comb begin
    a_row = '0;
    b_col = '0;
    for (int k = 0; k < pN; k++) begin
      a_row[k*pDATA_WIDTH +: pDATA_WIDTH] = a_buf[row * N_IDX + pIDX_W'(k)];
      b_col[k*pDATA_WIDTH +: pDATA_WIDTH] = b_buf[pIDX_W'(k) * N_IDX + col];
    end
  end

  matmul_dot_n #(
    .pDATA_WIDTH (pDATA_WIDTH),
    .pN          (pN)
  ) u_dot (
    .is_signed (signed_q),
    .a_row     (a_row),
    .b_col     (b_col),
    .dot       (dot)
  );

  always_ff @(posedge axis_clk or posedge axis_rst_n) begin
    if (axis_rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      signed_q <= 1'b0;
      err      <= 1'b0;
      for (int n = 0; n < NN; n++) begin
        a_buf[n] <= '0;
        b_buf[n] <= '0;
        c_buf[n] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: if (ss_hs) begin
          a_buf[0] <= ss.tdata;
          signed_q <= cfg_signed;
          if (ss.tlast) begin
            err <= 1'b1;
          end else begin
            idx   <= pIDX_W'(1);
            state <= ST_LOAD_A;
          end
        end
        ST_LOAD_A: if (ss_hs) begin
          a_buf[idx] <= ss.tdata;
          if (ss.tlast) begin
            err   <= 1'b1;
            idx   <= '0;
            state <= ST_IDLE;
          end else if (at_last) begin
            idx   <= '0;
            state <= ST_LOAD_B;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_LOAD_B: if (ss_hs) begin
          b_buf[idx] <= ss.tdata;
          if (at_last) begin
            // A missing tlast is flagged but the frame is still computed.
            if (!ss.tlast) err <= 1'b1;
            idx   <= '0;
            state <= ST_COMPUTE;
          end else if (ss.tlast) begin
            err   <= 1'b1;
            idx   <= '0;
            state <= ST_IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_COMPUTE: begin
          c_buf[idx] <= dot;
          if (at_last) begin
            idx   <= '0;
            state <= ST_OUT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_OUT: if (sm.tready) begin
          if (at_last) begin
            idx   <= '0;
            state <= ST_IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          idx   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
